// File: rtl/led_blink_coder.sv
// ----------------------------------------------------------------------------
// led_blink_coder
//
// Shows a requested count N on a status LED as N blinks followed by a dark
// gap, then returns to idle. All phase lengths are measured in pulses of the
// divided timebase strobe `tick`, never in raw clocks.
//
// Ports:
//   clk        in   system clock, all state updates on posedge
//   reset      in   asynchronous active-high reset
//   tick       in   one-cycle timebase strobe (may be high on any cycle)
//   code       in   requested blink count (CODE_W bits, 0 is a no-op)
//   code_valid in   request strobe qualifying `code`
//   code_ready out  high only while idle (request accepted when valid&&ready)
//   led        out  registered LED drive, 1 = lit
//   busy       out  high whenever a sequence is in progress
//   done       out  one-cycle pulse on the first idle cycle after a sequence
// ----------------------------------------------------------------------------
module led_blink_coder #(
    parameter int CODE_W    = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              led,
    output logic              busy,
    output logic              done
);

    // The tick counter only has to reach the largest phase length minus one.
    localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
    localparam int TICK_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    logic [CODE_W-1:0]   blink_cnt_q;
    logic [CODE_W-1:0]   code_q;
    logic                led_q;
    logic                done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            code_q      <= '0;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless GAP completes below.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A zero request is consumed silently: no state change.
                    if (code_valid && (code != '0)) begin
                        code_q      <= code;
                        tick_cnt_q  <= '0;
                        blink_cnt_q <= '0;
                        state_q     <= ST_ON;
                        led_q       <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (tick) begin
                        if (tick_cnt_q == ON_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= ST_OFF;
                            led_q      <= 1'b0;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                        end
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (tick_cnt_q == OFF_LAST) begin
                            tick_cnt_q <= '0;
                            // code_q is never zero here, so the subtract cannot wrap.
                            if (blink_cnt_q == (code_q - CODE_W'(1))) begin
                                state_q <= ST_GAP;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + CODE_W'(1);
                                state_q     <= ST_ON;
                                led_q       <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (tick_cnt_q == GAP_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                            done_q     <= 1'b1;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end

    // Handshake and status are decoded from state alone, never from inputs.
    assign code_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign led        = led_q;
    assign done       = done_q;

endmodule

// File: tb/tb_led_blink_coder.sv
// ----------------------------------------------------------------------------
// tb_led_blink_coder
//
// Self-checking bench for led_blink_coder with default parameters
// (CODE_W=4, ON=2, OFF=2, GAP=4). A table of per-cycle vectors covers the
// idle/zero-code behaviour and the code=3 sequence with tick held high;
// hand-written sequences cover reset mid-blink, sparse ticks, requests
// presented while busy, back-to-back acceptance and the maximum code.
// ----------------------------------------------------------------------------
module tb_led_blink_coder;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       led;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    led_blink_coder #(
        .CODE_W   (4),
        .ON_TICKS (2),
        .OFF_TICKS(2),
        .GAP_TICKS(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .code      (code),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       vld;
        logic [3:0] cd;
        logic       tk;
        logic       exp_led;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ready;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge: outputs there belong to
    // the new cycle, and inputs driven there are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises, dones, busy_cycles, on_ticks, dark_ticks;
        logic prev_led, seen;

        n_tests = 0;
        n_fail  = 0;

        // Rows 0-2: idle, including a zero-code request.
        // Rows 3-21: code=3 accepted in cycle 0 (row 3), cycles 0..18, tick=1.
        //                 vld   cd     tk    led   busy  done  rdy
        vecs[0]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // cyc 0
        vecs[4]  = '{1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // cyc 1
        vecs[5]  = '{1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // cyc 2
        vecs[6]  = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 3
        vecs[7]  = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 4
        vecs[8]  = '{1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // cyc 5
        vecs[9]  = '{1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // cyc 6
        vecs[10] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 7
        vecs[11] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 8
        vecs[12] = '{1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // cyc 9
        vecs[13] = '{1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // cyc 10
        vecs[14] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 11
        vecs[15] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 12
        vecs[16] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 13 gap
        vecs[17] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 14 gap
        vecs[18] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 15 gap
        vecs[19] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // cyc 16 gap
        vecs[20] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // cyc 17 done
        vecs[21] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // cyc 18

        // ---------------- reset state ----------------
        reset      = 1'b1;
        tick       = 1'b0;
        code       = 4'd0;
        code_valid = 1'b0;
        step();
        step();
        check("reset.led",   int'(led),        0);
        check("reset.done",  int'(done),       0);
        check("reset.busy",  int'(busy),       0);
        check("reset.ready", int'(code_ready), 1);
        reset = 1'b0;
        step();
        $display("[TB] reset: led=%0d done=%0d busy=%0d ready=%0d", led, done, busy, code_ready);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < NV; v++) begin
            check($sformatf("vec%0d.led", v),   int'(led),        int'(vecs[v].exp_led));
            check($sformatf("vec%0d.busy", v),  int'(busy),       int'(vecs[v].exp_busy));
            check($sformatf("vec%0d.done", v),  int'(done),       int'(vecs[v].exp_done));
            check($sformatf("vec%0d.ready", v), int'(code_ready), int'(vecs[v].exp_ready));
            $display("[TB] vec%0d: vld=%0d code=%0d tick=%0d -> led=%0d busy=%0d done=%0d ready=%0d",
                     v, vecs[v].vld, vecs[v].cd, vecs[v].tk, led, busy, done, code_ready);
            code_valid = vecs[v].vld;
            code       = vecs[v].cd;
            tick       = vecs[v].tk;
            step();
        end
        code_valid = 1'b0;

        // ---------------- reset mid-ON of a code-5 sequence ----------------
        tick       = 1'b1;
        code       = 4'd5;
        code_valid = 1'b1;
        step();                 // cycle 1: ON
        code_valid = 1'b0;
        step();                 // cycle 2: still ON
        check("rst_mid.led_before", int'(led), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid.led",   int'(led),        0);
        check("rst_mid.busy",  int'(busy),       0);
        check("rst_mid.ready", int'(code_ready), 1);
        check("rst_mid.done",  int'(done),       0);
        step();
        reset = 1'b0;
        rises = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (led)  rises++;
            if (done) dones++;
        end
        check("rst_mid.no_led_after", rises, 0);
        check("rst_mid.no_done",      dones, 0);
        $display("[TB] reset mid-ON: led_cycles=%0d dones=%0d", rises, dones);

        // ---------------- sparse ticks, code=1 ----------------
        rises = 0; dones = 0; on_ticks = 0; dark_ticks = 0; seen = 1'b0;
        prev_led = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (led && !prev_led) rises++;
            prev_led = led;
            if (done) begin
                dones++;
                seen = 1'b1;
                break;
            end
            tick       = (i % 4 == 3);
            code_valid = (i == 0);
            code       = 4'd1;
            if (tick && led)          on_ticks++;
            if (tick && !led && busy) dark_ticks++;
            step();
        end
        code_valid = 1'b0;
        check("sparse.done_seen",  int'(seen), 1);
        check("sparse.blinks",     rises,      1);
        check("sparse.on_ticks",   on_ticks,   2);
        check("sparse.dark_ticks", dark_ticks, 6);
        $display("[TB] sparse code=1: blinks=%0d on_ticks=%0d dark_ticks=%0d done=%0d",
                 rises, on_ticks, dark_ticks, dones);

        // ---------------- request ignored while busy, back-to-back ----------------
        tick       = 1'b1;
        code       = 4'd2;
        code_valid = 1'b1;
        step();
        rises = 0; seen = 1'b0; prev_led = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (led && !prev_led) rises++;
            prev_led = led;
            if (done) begin
                seen = 1'b1;
                check("busy_req.ready_in_done", int'(code_ready), 1);
                code       = 4'd1;
                code_valid = 1'b1;
                break;
            end
            // Keep a code=7 request asserted during the first ON phase.
            code       = 4'd7;
            code_valid = (i < 2);
            step();
        end
        check("busy_req.done_seen", int'(seen), 1);
        check("busy_req.blinks",    rises,      2);
        step();
        code_valid = 1'b0;
        check("b2b.led_next", int'(led),  1);
        check("b2b.busy",     int'(busy), 1);
        $display("[TB] code=2 with code=7 while busy: blinks=%0d; back-to-back led=%0d", rises, led);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b.done_seen", int'(seen), 1);

        // ---------------- max code 15, tick held high ----------------
        step();
        code       = 4'd15;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
        rises = 0; dones = 0; busy_cycles = 0; prev_led = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (led && !prev_led) rises++;
            prev_led = led;
            if (busy) busy_cycles++;
            if (done) dones++;
            step();
        end
        check("max.blinks",      rises,       15);
        check("max.done_pulses", dones,       1);
        check("max.busy_cycles", busy_cycles, 64);
        check("max.idle_after",  int'(busy),  0);
        $display("[TB] code=15: blinks=%0d dones=%0d busy_cycles=%0d", rises, dones, busy_cycles);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
